// File: rtl/ac_upsp_port_if.sv
// Signal bundle between the access-control endpoint and its peers:
// frame control, source/sink AXI-Stream and the upsp read/write channels.
interface ac_upsp_port_if #(
    parameter int CRF_DATA_WIDTH  = 32,
    parameter int UPSP_DATA_WIDTH = 24
);
    logic                       cfg_start;
    logic                       s_axis_tvalid;
    logic                       s_axis_tready;
    logic [UPSP_DATA_WIDTH-1:0] s_axis_tdata;
    logic [CRF_DATA_WIDTH-1:0]  UPSTR;
    logic [CRF_DATA_WIDTH-1:0]  UPENDR;
    logic                       upsp_ac_rd;
    logic                       ac_upsp_rvalid;
    logic [UPSP_DATA_WIDTH-1:0] ac_upsp_rdata;
    logic                       upsp_ac_wrt;
    logic                       ac_upsp_wready;
    logic [UPSP_DATA_WIDTH-1:0] upsp_ac_wdata;
    logic                       m_axis_tvalid;
    logic                       m_axis_tready;
    logic [UPSP_DATA_WIDTH-1:0] m_axis_tdata;
    logic                       m_axis_tlast;
    logic                       busy;
    logic                       frame_done;

    modport slave (
        input  cfg_start, s_axis_tvalid, s_axis_tdata, UPENDR,
        input  upsp_ac_rd, upsp_ac_wrt, upsp_ac_wdata, m_axis_tready,
        output s_axis_tready, UPSTR, ac_upsp_rvalid, ac_upsp_rdata,
        output ac_upsp_wready, m_axis_tvalid, m_axis_tdata,
        output m_axis_tlast, busy, frame_done
    );

    modport master (
        output cfg_start, s_axis_tvalid, s_axis_tdata, UPENDR,
        output upsp_ac_rd, upsp_ac_wrt, upsp_ac_wdata, m_axis_tready,
        input  s_axis_tready, UPSTR, ac_upsp_rvalid, ac_upsp_rdata,
        input  ac_upsp_wready, m_axis_tvalid, m_axis_tdata,
        input  m_axis_tlast, busy, frame_done
    );
endinterface

// File: rtl/ac_upsp_port.sv
// Access-control endpoint of the upsp port: source pixel buffering,
// up-sampled pixel forwarding and UPSTR/UPENDR frame sequencing.
module ac_upsp_port #(
    parameter int CRF_DATA_WIDTH  = 32,
    parameter int UPSP_DATA_WIDTH = 24,
    parameter int RD_DEPTH        = 8,
    parameter int WR_DEPTH        = 8,
    parameter int OUT_PIXELS      = 8294400
) (
    input logic           clk,
    input logic           rst_n,
    ac_upsp_port_if.slave bus
);
    localparam int RA = $clog2(RD_DEPTH);
    localparam int WA = $clog2(WR_DEPTH);
    localparam logic [31:0] OUT_N = 32'(OUT_PIXELS);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, state_nx;
    logic   st_run, st_act, st_done, st_busy;

    logic [UPSP_DATA_WIDTH-1:0] rd_mem [RD_DEPTH];
    logic [RA:0]                rd_wp, rd_rp;
    logic                       rd_full, rd_empty, rd_push, rd_pop;

    logic [UPSP_DATA_WIDTH-1:0] wr_mem [WR_DEPTH];
    logic [WA:0]                wr_wp, wr_rp;
    logic                       wr_full, wr_empty, wr_push, wr_pop;

    logic [31:0]                wr_cnt, out_cnt;
    logic                       out_valid, out_last;
    logic [UPSP_DATA_WIDTH-1:0] out_data;
    logic                       start, flush;
    logic                       unused_upendr;

    assign unused_upendr = ^bus.UPENDR[CRF_DATA_WIDTH-1:1];

    assign start = (state == IDLE) && bus.cfg_start;
    assign flush = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.cfg_start) state_nx = RUN;
            RUN:     if (wr_push && wr_cnt == OUT_N - 32'd1)
                         state_nx = DRAIN;
            DRAIN:   if (wr_empty && !out_valid && bus.UPENDR[0])
                         state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        st_run  = 1'b0;
        st_act  = 1'b0;
        st_done = 1'b0;
        st_busy = 1'b1;
        unique case (state)
            IDLE:    st_busy = 1'b0;
            RUN:     begin st_run = 1'b1; st_act = 1'b1; end
            DRAIN:   st_act = 1'b1;
            DONE:    st_done = 1'b1;
            default: st_busy = 1'b0;
        endcase
    end

    assign bus.UPSTR      = {{(CRF_DATA_WIDTH-1){1'b0}}, st_act};
    assign bus.busy       = st_busy;
    assign bus.frame_done = st_done;

    // Read FIFO: extra pointer bit separates full from empty
    assign rd_empty = (rd_wp == rd_rp);
    assign rd_full  = (rd_wp[RA] != rd_rp[RA]) &&
                      (rd_wp[RA-1:0] == rd_rp[RA-1:0]);

    assign bus.s_axis_tready  = st_run && !rd_full;
    assign bus.ac_upsp_rvalid = st_act && !rd_empty;
    assign bus.ac_upsp_rdata  = bus.ac_upsp_rvalid ?
                                rd_mem[rd_rp[RA-1:0]] : '0;

    assign rd_push = bus.s_axis_tvalid && bus.s_axis_tready;
    assign rd_pop  = bus.upsp_ac_rd && bus.ac_upsp_rvalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_wp <= '0;
            rd_rp <= '0;
        end else if (flush) begin
            rd_wp <= '0;
            rd_rp <= '0;
        end else begin
            if (rd_push) rd_wp <= rd_wp + (RA+1)'(1);
            if (rd_pop)  rd_rp <= rd_rp + (RA+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rd_push) rd_mem[rd_wp[RA-1:0]] <= bus.s_axis_tdata;
    end

    // Write FIFO and per-frame pixel counters
    assign wr_empty = (wr_wp == wr_rp);
    assign wr_full  = (wr_wp[WA] != wr_rp[WA]) &&
                      (wr_wp[WA-1:0] == wr_rp[WA-1:0]);

    assign bus.ac_upsp_wready = st_run && !wr_full && (wr_cnt < OUT_N);
    assign wr_push = bus.upsp_ac_wrt && bus.ac_upsp_wready;
    assign wr_pop  = !wr_empty && (!out_valid || bus.m_axis_tready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_wp   <= '0;
            wr_rp   <= '0;
            wr_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            if (wr_push) wr_wp <= wr_wp + (WA+1)'(1);
            if (wr_pop)  wr_rp <= wr_rp + (WA+1)'(1);
            if (start)        wr_cnt <= '0;
            else if (wr_push) wr_cnt <= wr_cnt + 32'd1;
            if (start)       out_cnt <= '0;
            else if (wr_pop) out_cnt <= out_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_push) wr_mem[wr_wp[WA-1:0]] <= bus.upsp_ac_wdata;
    end

    // Output register holds data/last steady while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (wr_pop) begin
            out_valid <= 1'b1;
            out_data  <= wr_mem[wr_rp[WA-1:0]];
            out_last  <= (out_cnt == OUT_N - 32'd1);
        end else if (bus.m_axis_tready) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.m_axis_tvalid = out_valid;
    assign bus.m_axis_tdata  = out_data;
    assign bus.m_axis_tlast  = out_last;
endmodule

// File: tb/tb_ac_upsp_port.sv
// Scoreboard bench for ac_upsp_port: one DUT with 8-pixel frames and
// a second with 16-pixel frames for the output-stall scenario.
module tb_ac_upsp_port;
    localparam int DW = 24;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errs = 0;
    int   checks = 0;

    logic [DW-1:0] q_rd[$];
    logic [DW:0]   q_wr[$];

    always #5 clk = ~clk;

    ac_upsp_port_if #(.CRF_DATA_WIDTH(CW), .UPSP_DATA_WIDTH(DW)) b();
    ac_upsp_port_if #(.CRF_DATA_WIDTH(CW), .UPSP_DATA_WIDTH(DW)) b2();

    ac_upsp_port #(
        .CRF_DATA_WIDTH(CW), .UPSP_DATA_WIDTH(DW),
        .RD_DEPTH(8), .WR_DEPTH(8), .OUT_PIXELS(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(b.slave)
    );

    ac_upsp_port #(
        .CRF_DATA_WIDTH(CW), .UPSP_DATA_WIDTH(DW),
        .RD_DEPTH(8), .WR_DEPTH(8), .OUT_PIXELS(16)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(b2.slave)
    );

    task automatic idle_inputs();
        b.cfg_start = 0; b.s_axis_tvalid = 0; b.s_axis_tdata = '0;
        b.UPENDR = '0; b.upsp_ac_rd = 0; b.upsp_ac_wrt = 0;
        b.upsp_ac_wdata = '0; b.m_axis_tready = 0;
        b2.cfg_start = 0; b2.s_axis_tvalid = 0; b2.s_axis_tdata = '0;
        b2.UPENDR = '0; b2.upsp_ac_rd = 0; b2.upsp_ac_wrt = 0;
        b2.upsp_ac_wdata = '0; b2.m_axis_tready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({b.UPSTR, b.s_axis_tready, b.ac_upsp_rvalid, b.ac_upsp_rdata,
             b.ac_upsp_wready, b.m_axis_tvalid, b.m_axis_tdata,
             b.m_axis_tlast, b.busy, b.frame_done} !== '0)
            begin errs++; $display("FAIL reset_outputs: some output nonzero, UPSTR=%h busy=%b", b.UPSTR, b.busy); end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic start_frame();
        @(posedge clk); #1;
        b.cfg_start = 1;
        @(posedge clk); #1;
        b.cfg_start = 0;
        checks++;
        if ({b.UPSTR, b.busy, b.s_axis_tready} !== {32'h1, 1'b1, 1'b1})
            begin errs++; $display("FAIL start: UPSTR=%h busy=%b tready=%b, expected 1/1/1", b.UPSTR, b.busy, b.s_axis_tready); end
    endtask

    task automatic test_read_flow();
        int sent = 0, got = 0, cyc = 0;
        int first_push = -1, first_pop = -1, last_pop = 0;
        logic [DW-1:0] exp;
        b.upsp_ac_rd = 1;
        while (got < 8 && cyc < 40) begin
            @(posedge clk); #1;
            b.s_axis_tvalid = (sent < 8);
            b.s_axis_tdata  = DW'(sent + 1);
            @(negedge clk);
            if (b.ac_upsp_rvalid && b.upsp_ac_rd) begin
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                checks++;
                if (q_rd.size() == 0) begin
                    errs++; $display("FAIL rd_flow_extra: rdata=%h with nothing pushed", b.ac_upsp_rdata);
                end else begin
                    exp = q_rd.pop_front();
                    if (b.ac_upsp_rdata !== exp) begin errs++; $display("FAIL rd_flow_data: got %h expected %h", b.ac_upsp_rdata, exp); end
                end
                got++;
            end
            if (b.s_axis_tvalid && b.s_axis_tready) begin
                if (first_push < 0) first_push = cyc;
                q_rd.push_back(b.s_axis_tdata);
                sent++;
            end
            cyc++;
        end
        b.s_axis_tvalid = 0;
        checks++;
        if (got != 8) begin errs++; $display("FAIL rd_flow_count: got %0d expected 8", got); end
        checks++;
        if (first_pop != first_push + 1) begin errs++; $display("FAIL rd_flow_latency: pop cycle %0d expected %0d", first_pop, first_push + 1); end
        checks++;
        if (last_pop - first_pop != 7) begin errs++; $display("FAIL rd_flow_rate: span %0d expected 7", last_pop - first_pop); end
    endtask

    task automatic test_write_tlast();
        int sent = 0, got = 0, cyc = 0;
        int first_w = -1, first_m = -1;
        logic [DW:0] exp;
        b.m_axis_tready = 1;
        while (got < 8 && cyc < 40) begin
            @(posedge clk); #1;
            b.upsp_ac_wrt   = (sent < 8);
            b.upsp_ac_wdata = 24'hA00000 + DW'(sent);
            @(negedge clk);
            if (b.m_axis_tvalid && b.m_axis_tready) begin
                if (first_m < 0) first_m = cyc;
                checks++;
                if (q_wr.size() == 0) begin
                    errs++; $display("FAIL wr_extra: tdata=%h with nothing written", b.m_axis_tdata);
                end else begin
                    exp = q_wr.pop_front();
                    if ({b.m_axis_tlast, b.m_axis_tdata} !== exp) begin errs++; $display("FAIL wr_data: got last=%b data=%h expected last=%b data=%h", b.m_axis_tlast, b.m_axis_tdata, exp[DW], exp[DW-1:0]); end
                end
                got++;
            end
            if (b.upsp_ac_wrt && b.ac_upsp_wready) begin
                if (first_w < 0) first_w = cyc;
                q_wr.push_back({sent == 7, b.upsp_ac_wdata});
                sent++;
            end
            cyc++;
        end
        b.upsp_ac_wrt = 0;
        checks++;
        if (got != 8) begin errs++; $display("FAIL wr_count: got %0d expected 8", got); end
        checks++;
        if (first_m != first_w + 2) begin errs++; $display("FAIL wr_latency: m cycle %0d expected %0d", first_m, first_w + 2); end
        @(negedge clk);
        checks++;
        if ({b.ac_upsp_wready, b.busy, b.UPSTR[0]} !== 3'b011) begin errs++; $display("FAIL wr_after_frame: wready=%b busy=%b run=%b expected 0/1/1", b.ac_upsp_wready, b.busy, b.UPSTR[0]); end
    endtask

    task automatic test_frame_end();
        int pulses = 0;
        b.UPENDR = '0;
        repeat (5) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (b.frame_done) pulses++;
        end
        checks++;
        if (b.UPSTR !== 32'h1) begin errs++; $display("FAIL end_hold: UPSTR=%h expected 1", b.UPSTR); end
        @(posedge clk); #1;
        b.UPENDR = 32'h1;
        @(negedge clk);
        if (b.frame_done) pulses++;
        checks++;
        if (b.frame_done !== 1'b0) begin errs++; $display("FAIL end_early: frame_done=%b expected 0", b.frame_done); end
        @(posedge clk); #1;
        @(negedge clk);
        if (b.frame_done) pulses++;
        checks++;
        if ({b.frame_done, b.UPSTR, b.busy} !== {1'b1, 32'h0, 1'b1}) begin errs++; $display("FAIL end_done: frame_done=%b UPSTR=%h busy=%b expected 1/0/1", b.frame_done, b.UPSTR, b.busy); end
        @(posedge clk); #1;
        @(negedge clk);
        if (b.frame_done) pulses++;
        checks++;
        if (b.busy !== 1'b0) begin errs++; $display("FAIL end_idle: busy=%b expected 0", b.busy); end
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (b.frame_done) pulses++;
        end
        b.UPENDR = '0;
        checks++;
        if (pulses != 1) begin errs++; $display("FAIL end_pulses: saw %0d expected 1", pulses); end
    endtask

    task automatic test_read_backpressure();
        int sent = 0, got = 0, cyc = 0;
        logic [DW-1:0] exp;
        while (got < 10 && cyc < 50) begin
            @(posedge clk); #1;
            b.upsp_ac_rd    = (cyc >= 14);
            b.s_axis_tvalid = (sent < 10);
            b.s_axis_tdata  = 24'hC00000 + DW'(sent);
            @(negedge clk);
            if (cyc == 13) begin
                checks++;
                if (sent != 8 || b.s_axis_tready !== 1'b0) begin errs++; $display("FAIL bp_full: accepted %0d tready=%b expected 8/0", sent, b.s_axis_tready); end
            end
            if (b.ac_upsp_rvalid && b.upsp_ac_rd) begin
                checks++;
                if (q_rd.size() == 0) begin
                    errs++; $display("FAIL bp_extra: rdata=%h with nothing pushed", b.ac_upsp_rdata);
                end else begin
                    exp = q_rd.pop_front();
                    if (b.ac_upsp_rdata !== exp) begin errs++; $display("FAIL bp_data: got %h expected %h", b.ac_upsp_rdata, exp); end
                end
                got++;
            end
            if (b.s_axis_tvalid && b.s_axis_tready) begin
                q_rd.push_back(b.s_axis_tdata);
                sent++;
            end
            cyc++;
        end
        b.s_axis_tvalid = 0;
        b.upsp_ac_rd = 0;
        checks++;
        if (got != 10 || sent != 10 || q_rd.size() != 0) begin errs++; $display("FAIL bp_total: got %0d sent %0d left %0d expected 10/10/0", got, sent, q_rd.size()); end
    endtask

    task automatic test_reset_midframe();
        b.m_axis_tready = 0;
        repeat (3) begin
            @(posedge clk); #1;
            b.s_axis_tvalid = 1; b.s_axis_tdata = 24'h777777;
            b.upsp_ac_wrt = 1; b.upsp_ac_wdata = 24'h888888;
        end
        @(posedge clk); #1;
        b.s_axis_tvalid = 0; b.upsp_ac_wrt = 0;
        @(negedge clk);
        checks++;
        if ({b.ac_upsp_rvalid, b.m_axis_tvalid} !== 2'b11) begin errs++; $display("FAIL rst_pre: rvalid=%b tvalid=%b expected 1/1", b.ac_upsp_rvalid, b.m_axis_tvalid); end
        #2 rst_n = 0;
        #1;
        checks++;
        if ({b.UPSTR, b.s_axis_tready, b.ac_upsp_rvalid, b.ac_upsp_rdata,
             b.ac_upsp_wready, b.m_axis_tvalid, b.m_axis_tdata,
             b.m_axis_tlast, b.busy, b.frame_done} !== '0)
            begin errs++; $display("FAIL rst_async: outputs nonzero, rvalid=%b tvalid=%b tdata=%h", b.ac_upsp_rvalid, b.m_axis_tvalid, b.m_axis_tdata); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        q_rd.delete();
        q_wr.delete();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (b.busy !== 1'b0) begin errs++; $display("FAIL rst_hold_idle: busy=%b expected 0", b.busy); end
        start_frame();
        checks++;
        if ({b.ac_upsp_rvalid, b.m_axis_tvalid} !== 2'b00) begin errs++; $display("FAIL rst_fifo_clear: rvalid=%b tvalid=%b expected 0/0", b.ac_upsp_rvalid, b.m_axis_tvalid); end
        b.s_axis_tvalid = 1; b.s_axis_tdata = 24'h5A5A5A;
        @(posedge clk); #1;
        b.s_axis_tvalid = 0;
        checks++;
        if ({b.ac_upsp_rvalid, b.ac_upsp_rdata} !== {1'b1, 24'h5A5A5A}) begin errs++; $display("FAIL rst_resume: rvalid=%b rdata=%h expected 1/5a5a5a", b.ac_upsp_rvalid, b.ac_upsp_rdata); end
    endtask

    task automatic test_output_stall();
        int sent = 0, got = 0, cyc = 0;
        logic [DW:0] exp;
        @(posedge clk); #1;
        b2.cfg_start = 1;
        @(posedge clk); #1;
        b2.cfg_start = 0;
        while (got < 10 && cyc < 60) begin
            @(posedge clk); #1;
            b2.m_axis_tready = (cyc >= 16);
            b2.upsp_ac_wrt   = (sent < 10);
            b2.upsp_ac_wdata = 24'hB00000 + DW'(sent);
            @(negedge clk);
            if (cyc == 15) begin
                checks++;
                if (sent != 9 || b2.ac_upsp_wready !== 1'b0) begin errs++; $display("FAIL stall_accept: accepted %0d wready=%b expected 9/0", sent, b2.ac_upsp_wready); end
                checks++;
                if ({b2.m_axis_tvalid, b2.m_axis_tdata} !== {1'b1, 24'hB00000}) begin errs++; $display("FAIL stall_hold: tvalid=%b tdata=%h expected 1/b00000", b2.m_axis_tvalid, b2.m_axis_tdata); end
            end
            if (b2.m_axis_tvalid && b2.m_axis_tready) begin
                checks++;
                if (q_wr.size() == 0) begin
                    errs++; $display("FAIL stall_extra: tdata=%h with nothing written", b2.m_axis_tdata);
                end else begin
                    exp = q_wr.pop_front();
                    if ({b2.m_axis_tlast, b2.m_axis_tdata} !== exp) begin errs++; $display("FAIL stall_data: got last=%b data=%h expected last=%b data=%h", b2.m_axis_tlast, b2.m_axis_tdata, exp[DW], exp[DW-1:0]); end
                end
                got++;
            end
            if (b2.upsp_ac_wrt && b2.ac_upsp_wready) begin
                q_wr.push_back({1'b0, b2.upsp_ac_wdata});
                sent++;
            end
            cyc++;
        end
        b2.upsp_ac_wrt = 0;
        checks++;
        if (got != 10) begin errs++; $display("FAIL stall_total: delivered %0d expected 10", got); end
    endtask

    initial begin
        test_reset();
        start_frame();
        test_read_flow();
        test_write_tlast();
        test_frame_end();
        start_frame();
        test_read_backpressure();
        test_reset_midframe();
        test_output_stall();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
